vga_image_reader: RTL

Read-side client of the 256x256 1-bpp image RAM, sitting between the VGA sync generator and the RAM. Once per scan line it fetches one image row (one RAM word) into a line buffer during horizontal blanking. It then serialises that row into RGB pixels for a centred 256x256 window on the 640x480 display. It never writes the RAM.

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_image_reader_if.sv | 12 +
 rtl/vga_image_reader.sv | 99 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and the image-reader fetch FSM encoding.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_BLANK  = 160;

  // Default origin centres a 256x256 image on the 640x480 visible area.
  localparam int unsigned X0_DEFAULT = 192;
  localparam int unsigned Y0_DEFAULT = 112;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/vga_image_reader_if.sv
// Read port of the image RAM: the reader is master, the RAM is slave.
interface vga_image_reader_if #(
  parameter int unsigned AddressWidth = 16,
  parameter int unsigned DataWidth    = 256
);
  logic                    ram_rw;
  logic [AddressWidth-1:0] ram_addr;
  logic [DataWidth-1:0]    ram_data;

  modport master (output ram_rw, output ram_addr, input ram_data);
  modport slave  (input ram_rw, input ram_addr, output ram_data);
endinterface

// File: rtl/vga_image_reader.sv
// Fetches one image row per scan line into a line buffer and serialises it as
// RGB pixels for a window on the VGA display.
module vga_image_reader
  import vga_pkg::*;
#(
  parameter int unsigned AddressWidth = 16,
  parameter int unsigned DataWidth    = 256,
  parameter int unsigned ImgRows      = 256,
  parameter int unsigned X0           = X0_DEFAULT,
  parameter int unsigned Y0           = Y0_DEFAULT,
  parameter logic [2:0]  FgColor      = 3'b111,
  parameter logic [2:0]  BgColor      = 3'b000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                line_start,
  input  logic [9:0]          hc,
  input  logic [9:0]          vc,
  input  logic                activevideo,
  vga_image_reader_if.master  ram,
  output logic [2:0]          pixel_rgb,
  output logic                busy
);

  localparam int unsigned IdxW = $clog2(DataWidth);
  // Bounds carry an extra bit so X0+DataWidth and Y0+ImgRows never wrap.
  localparam logic [10:0] XLo = 11'(X0);
  localparam logic [10:0] XHi = 11'(X0 + DataWidth);
  localparam logic [10:0] YLo = 11'(Y0);
  localparam logic [10:0] YHi = 11'(Y0 + ImgRows);

  state_e                  state_q, state_d;
  logic [DataWidth-1:0]    line_buf_q;
  logic [AddressWidth-1:0] addr_q;
  logic [2:0]              pixel_q, pixel_d;
  logic                    load, capture;
  logic                    x_in, y_in, in_win, pix_bit;
  logic [IdxW-1:0]         col;

  assign x_in    = ({1'b0, hc} >= XLo) && ({1'b0, hc} < XHi);
  assign y_in    = ({1'b0, vc} >= YLo) && ({1'b0, vc} < YHi);
  assign in_win  = activevideo && x_in && y_in;
  assign col     = IdxW'(hc - 10'(X0));
  // Image column 0 is the MSB of the RAM word.
  assign pix_bit = line_buf_q[IdxW'(DataWidth - 1) - col];

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (line_start && y_in) begin
          state_d = ST_READ;
          load    = 1'b1;
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        capture = 1'b1;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pixel_d = BgColor;
    if (!activevideo) begin
      pixel_d = 3'b000;
    end else if (in_win) begin
      pixel_d = pix_bit ? FgColor : BgColor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      line_buf_q <= '0;
      pixel_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      pixel_q <= pixel_d;
      if (load) begin
        addr_q <= AddressWidth'(vc - 10'(Y0));
      end
      if (capture) begin
        line_buf_q <= ram.ram_data;
      end
    end
  end

  assign busy         = (state_q == ST_READ) || (state_q == ST_CAPTURE);
  assign ram.ram_rw   = 1'b1;
  assign ram.ram_addr = addr_q;
  assign pixel_rgb    = pixel_q;

endmodule
